// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file widths, zero-register constant and writeback entry record.
package wb_arbiter_pkg;
  localparam int WB_WIDTH      = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int ZERO_REG      = 0;
  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_WIDTH-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result FIFO whose entries can be squashed by destination register.
module wb_fifo #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     i_push,
  input  logic [ADDR_WIDTH-1:0]    i_push_rd,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_sq_en,
  input  logic [ADDR_WIDTH-1:0]    i_sq_rd,
  input  logic [ADDR_WIDTH-1:0]    i_query_addr,
  output logic                     o_head_valid,
  output logic [ADDR_WIDTH-1:0]    o_head_rd,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_query_match
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
  logic [WIDTH-1:0]      r_data [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      w_match;
  // Squash first, then pop/push: a same-cycle push is newer and keeps its valid bit.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_sq_en && r_rd[i] == i_sq_rd) r_valid[i] <= 1'b0;
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_rd[r_wptr]   <= i_push_rd;
      r_data[r_wptr] <= i_push_data;
    end
  end
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) w_match[i] = r_valid[i] && r_rd[i] == i_query_addr;
  end
  assign o_head_valid  = r_valid[r_rptr];
  assign o_head_rd     = r_rd[r_rptr];
  assign o_head_data   = r_data[r_rptr];
  assign o_count       = r_count;
  assign o_query_match = |w_match;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load writebacks into one registered register-file write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = WB_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   alu_valid,
  input  logic [ADDR_WIDTH-1:0]  alu_rd,
  input  logic [WIDTH-1:0]       alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_WIDTH-1:0]  mem_rd,
  input  logic [WIDTH-1:0]       mem_data,
  input  logic [ADDR_WIDTH-1:0]  query_addr,
  output logic                   query_hit,
  output logic                   regWriteEnable,
  output logic [ADDR_WIDTH-1:0]  addrD,
  output logic [WIDTH-1:0]       dataD,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);
  logic                  w_alu_issue, w_push, w_pop, w_fifo_issue, w_we;
  logic                  w_head_valid, w_fifo_hit;
  logic [ADDR_WIDTH-1:0] w_head_rd, w_addr;
  logic [WIDTH-1:0]      w_head_data, w_data;
  logic [CW-1:0]         w_count;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_data;
  assign mem_ready    = (w_count < CW'(DEPTH)) && clear;
  assign w_push       = mem_valid && mem_ready && mem_rd != ZR;
  assign w_alu_issue  = alu_valid && alu_rd != ZR;
  assign w_pop        = !w_alu_issue && w_count != '0;
  assign w_fifo_issue = w_pop && w_head_valid;
  wb_fifo #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .clear        (clear),
    .i_push       (w_push),
    .i_push_rd    (mem_rd),
    .i_push_data  (mem_data),
    .i_pop        (w_pop),
    .i_sq_en      (w_alu_issue),
    .i_sq_rd      (alu_rd),
    .i_query_addr (query_addr),
    .o_head_valid (w_head_valid),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .o_query_match(w_fifo_hit)
  );
  always_comb begin
    w_we   = w_alu_issue || w_fifo_issue;
    w_addr = w_alu_issue ? alu_rd : w_fifo_issue ? w_head_rd : '0;
    w_data = w_alu_issue ? alu_data : w_fifo_issue ? w_head_data : '0;
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we   <= w_we;
      r_addr <= w_addr;
      r_data <= w_data;
    end
  end
  assign query_hit = query_addr != ZR && (w_fifo_hit || (r_we && r_addr == query_addr) ||
                     (mem_valid && mem_ready && mem_rd == query_addr));
  assign regWriteEnable = r_we;
  assign addrD          = r_addr;
  assign dataD          = r_data;
  assign fifo_count     = w_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, reset sequences and a queue-based random reference check.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int W = 32, AW = 5, D = 4, CW = 3;
  logic          clock = 0, clear = 0;
  logic          alu_valid = 0, mem_valid = 0;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0, query_addr = '0;
  logic [W-1:0]  alu_data = '0, mem_data = '0;
  logic          mem_ready, query_hit, regWriteEnable;
  logic [AW-1:0] addrD;
  logic [W-1:0]  dataD;
  logic [CW-1:0] fifo_count;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  wb_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clock(clock), .clear(clear),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .query_addr(query_addr), .query_hit(query_hit),
    .regWriteEnable(regWriteEnable), .addrD(addrD), .dataD(dataD), .fifo_count(fifo_count)
  );
  typedef struct {
    logic av; logic [AW-1:0] ar; logic [W-1:0] ad;
    logic mv; logic [AW-1:0] mr; logic [W-1:0] md;
    logic [AW-1:0] qa;
    logic rdy, hit, we; logic [AW-1:0] a; logic [W-1:0] d; logic [CW-1:0] cnt;
  } vec_t;
  vec_t vt[$];
  wb_entry_t mq[$];
  logic m_we; logic [AW-1:0] m_addr; logic [W-1:0] m_data;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic setin(input logic av, input logic [AW-1:0] ar, input logic [W-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [W-1:0] md,
                       input logic [AW-1:0] qa);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md; query_addr = qa;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_we"}, regWriteEnable, 0);
    chk({nm, "_addr"}, addrD, 0);
    chk({nm, "_data"}, dataD, 0);
  endtask
  initial begin
    logic er;
    logic eh;
    wb_entry_t e;
    // Reset state
    #2;
    chk_zero("rst");
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ready", mem_ready, 0);
    repeat (2) @(negedge clock);
    clear = 1;
    // Directed vectors: pre-edge ready/hit, post-edge write port and count
    vt.push_back('{0,0,0, 1,5,32'hDEADBEEF, 5, 1,1, 0,0,0, 1});
    vt.push_back('{0,0,0, 0,0,0, 5, 1,1, 1,5,32'hDEADBEEF, 0});
    vt.push_back('{0,0,0, 0,0,0, 5, 1,1, 0,0,0, 0});
    vt.push_back('{0,0,0, 0,0,0, 5, 1,0, 0,0,0, 0});
    for (int k = 0; k < 4; k++)
      vt.push_back('{1,7,32'h70+k, 1,k+1,32'h101+k, 0, 1,0, 1,7,32'h70+k, k+1});
    vt.push_back('{1,7,32'h74, 1,5,32'h105, 0, 0,0, 1,7,32'h74, 4});
    vt.push_back('{0,0,0, 0,0,0, 3, 0,1, 1,1,32'h101, 3});
    vt.push_back('{0,0,0, 0,0,0, 0, 1,0, 1,2,32'h102, 2});
    vt.push_back('{0,0,0, 0,0,0, 0, 1,0, 1,3,32'h103, 1});
    vt.push_back('{0,0,0, 0,0,0, 0, 1,0, 1,4,32'h104, 0});
    vt.push_back('{0,0,0, 1,9,32'h11, 9, 1,1, 0,0,0, 1});
    vt.push_back('{1,9,32'h22, 0,0,0, 9, 1,1, 1,9,32'h22, 1});
    vt.push_back('{0,0,0, 0,0,0, 9, 1,1, 0,0,0, 0});
    vt.push_back('{0,0,0, 0,0,0, 9, 1,0, 0,0,0, 0});
    vt.push_back('{1,8,32'h33, 1,8,32'h44, 8, 1,1, 1,8,32'h33, 1});
    vt.push_back('{0,0,0, 0,0,0, 8, 1,1, 1,8,32'h44, 0});
    vt.push_back('{0,0,0, 1,3,32'h333, 0, 1,0, 0,0,0, 1});
    vt.push_back('{1,0,32'h999, 1,0,32'h555, 0, 1,0, 1,3,32'h333, 0});
    vt.push_back('{0,0,0, 0,0,0, 0, 1,0, 0,0,0, 0});
    vt.push_back('{0,0,0, 1,10,32'hA, 10, 1,1, 0,0,0, 1});
    vt.push_back('{0,0,0, 1,11,32'hB, 10, 1,1, 1,10,32'hA, 1});
    vt.push_back('{0,0,0, 0,0,0, 11, 1,1, 1,11,32'hB, 0});
    foreach (vt[i]) begin
      setin(vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md, vt[i].qa);
      #1;
      chk($sformatf("v%0d_ready", i), mem_ready, vt[i].rdy);
      chk($sformatf("v%0d_hit", i), query_hit, vt[i].hit);
      @(posedge clock); #1;
      chk($sformatf("v%0d_we", i), regWriteEnable, vt[i].we);
      chk($sformatf("v%0d_addr", i), addrD, vt[i].a);
      chk($sformatf("v%0d_data", i), dataD, vt[i].d);
      chk($sformatf("v%0d_cnt", i), fifo_count, vt[i].cnt);
      @(negedge clock);
    end
    // Reset with three loads pending behind a busy ALU
    for (int k = 0; k < 3; k++) begin
      setin(1, 7, 32'h700 + k, 1, AW'(k + 1), 32'h500 + k, 0);
      @(posedge clock); @(negedge clock);
    end
    chk("pre_clr_cnt", fifo_count, 3);
    setin(0, 0, 0, 0, 0, 0, 0);
    clear = 0;
    #1;
    chk_zero("clr");
    chk("clr_cnt", fifo_count, 0);
    chk("clr_ready", mem_ready, 0);
    @(negedge clock);
    clear = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk($sformatf("post_clr%0d_we", k), regWriteEnable, 0);
      chk($sformatf("post_clr%0d_cnt", k), fifo_count, 0);
      @(negedge clock);
    end
    // First load after release reaches the write port on the second edge
    setin(0, 0, 0, 1, 12, 32'hC0FFEE, 0);
    @(posedge clock); #1;
    chk("first_edge_we", regWriteEnable, 0);
    @(negedge clock);
    setin(0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("second_edge_we", regWriteEnable, 1);
    chk("second_edge_addr", addrD, 12);
    chk("second_edge_data", dataD, 32'hC0FFEE);
    @(negedge clock);
    clear = 0;
    @(negedge clock);
    clear = 1;
    // Random traffic against a queue-of-entries reference
    mq.delete();
    m_we = 0; m_addr = '0; m_data = '0;
    for (int n = 0; n < 500; n++) begin
      setin(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)));
      #1;
      er = mq.size() < D;
      eh = 0;
      if (query_addr != 0) begin
        foreach (mq[i]) if (mq[i].valid && mq[i].rd == query_addr) eh = 1;
        if (m_we && m_addr == query_addr) eh = 1;
        if (mem_valid && er && mem_rd == query_addr) eh = 1;
      end
      chk("rnd_ready", mem_ready, er);
      chk("rnd_hit", query_hit, eh);
      @(posedge clock);
      if (alu_valid && alu_rd != 0) begin
        m_we = 1; m_addr = alu_rd; m_data = alu_data;
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].valid = 0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = e.valid; m_addr = e.valid ? e.rd : '0; m_data = e.valid ? e.data : '0;
      end else begin
        m_we = 0; m_addr = '0; m_data = '0;
      end
      if (mem_valid && er && mem_rd != 0) mq.push_back('{1'b1, mem_rd, mem_data});
      #1;
      chk("rnd_we", regWriteEnable, m_we);
      chk("rnd_addr", addrD, m_addr);
      chk("rnd_data", dataD, m_data);
      chk("rnd_cnt", fifo_count, mq.size());
      @(negedge clock);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
